xbar_slave_arbiter: RTL and testbench

- Per-slave arbiter of the cross-bar; one instance per slave port.
- Selects among N_MASTERS requesters whose address bits [31:30] equal SLAVE_ID, using round-robin priority.
- Muxes the winner's req/addr/cmd/wdata onto the slave port and routes ack/resp/rdata back.
- Holds the grant for one full transaction: until ack for a write, until resp for a read.

---
 rtl/xbar_pkg.sv | 12 +
 rtl/xbar_slave_arbiter_if.sv | 33 +++
 rtl/xbar_rr_pick.sv | 33 +++
 rtl/xbar_slave_arbiter.sv | 154 +++++++++++++++
 tb/tb_xbar_slave_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared types and constants for the cross-bar slave-side arbiter.
package xbar_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_RESP} arb_state_t;

  localparam int          ADDR_W        = 32;
  localparam int          DATA_W        = 32;
  localparam int          SEL_MSB       = 31;
  localparam int          SEL_LSB       = 30;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// Master-side and slave-side bus of one cross-bar slave port.
// master: the arbiter's view; slave: the view of the masters and slave it connects.
interface xbar_slave_arbiter_if #(parameter int N_MASTERS = 4);
  import xbar_pkg::*;

  logic [N_MASTERS-1:0]             m_req;
  logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [N_MASTERS-1:0]             m_cmd;
  logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]             m_ack;
  logic [N_MASTERS-1:0]             m_resp;
  logic [DATA_W-1:0]                m_rdata;
  logic                             s_req;
  logic [ADDR_W-1:0]                s_addr;
  logic                             s_cmd;
  logic [DATA_W-1:0]                s_wdata;
  logic                             s_ack;
  logic                             s_resp;
  logic [DATA_W-1:0]                s_rdata;
  logic [N_MASTERS-1:0]             grant;
  logic                             timeout_err;

  modport master (
    input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd, s_wdata, grant, timeout_err
  );

  modport slave (
    output m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
    input  m_ack, m_resp, m_rdata, s_req, s_addr, s_cmd, s_wdata, grant, timeout_err
  );

endinterface

// File: rtl/xbar_rr_pick.sv
// Round-robin picker: first eligible index at or after rr_ptr, wrapping upward.
// Purely combinational, zero latency; no backpressure.
module xbar_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vld
);
  localparam int IW = $clog2(N);

  int            c_int;
  logic [IW-1:0] c_idx;

  // Scan from farthest to nearest so the nearest eligible index is the last written.
  always_comb begin
    idx   = '0;
    vld   = 1'b0;
    c_int = 0;
    c_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c_int = int'(rr_ptr) + k;
      if (c_int >= N) c_int = c_int - N;
      c_idx = IW'(c_int);
      if (eligible[c_idx]) begin
        idx = c_idx;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave round-robin arbiter; grant held for a whole transaction; 1 idle bubble between grants.
// Optional watchdog abort under XBAR_ARB_TIMEOUT_EN; otherwise waits on the slave indefinitely.
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int SLAVE_ID       = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  xbar_slave_arbiter_if.master  bus
);
  localparam int         IW     = $clog2(N_MASTERS);
  localparam logic [1:0] SEL_ID = SLAVE_ID[1:0];

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("xbar_slave_arbiter: parameter out of range");
  end

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        gnt_idx, gnt_nxt;
  logic [IW-1:0]        rr_ptr, rr_nxt;
  logic [N_MASTERS-1:0] eligible;
  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;
  logic                 done;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      eligible[i] = bus.m_req[i] && (bus.m_addr[i][SEL_MSB:SEL_LSB] == SEL_ID);
    end
  end

  xbar_rr_pick #(.N(N_MASTERS)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .idx      (pick_idx),
    .vld      (pick_vld)
  );

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;
  logic            wd_expired;
  logic            to_fire;

  assign wd_expired      = (wdog == WD_W'(TIMEOUT_CYCLES));
  assign bus.timeout_err = to_fire;

  // Counts cycles spent in the current busy state; restarts on any state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog <= '0;
    end else if (state_nxt != state || state == ARB_IDLE) begin
      wdog <= '0;
    end else if (!wd_expired) begin
      wdog <= wdog + 1'b1;
    end
  end
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARB_IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt_idx;
    rr_nxt      = rr_ptr;
    done        = 1'b0;
    bus.s_req   = 1'b0;
    bus.s_addr  = '0;
    bus.s_cmd   = 1'b0;
    bus.s_wdata = '0;
    bus.m_ack   = '0;
    bus.m_resp  = '0;
    bus.m_rdata = bus.s_rdata;
    bus.grant   = '0;
`ifdef XBAR_ARB_TIMEOUT_EN
    to_fire     = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_nxt = ARB_ADDR;
          gnt_nxt   = pick_idx;
        end
      end
      ARB_ADDR: begin
        bus.grant[gnt_idx] = 1'b1;
        bus.s_req          = bus.m_req[gnt_idx];
        bus.s_addr         = bus.m_addr[gnt_idx];
        bus.s_cmd          = bus.m_cmd[gnt_idx];
        bus.s_wdata        = bus.m_wdata[gnt_idx];
        // A master withdrawing its request abandons the grant; a late ack is not forwarded.
        if (!bus.m_req[gnt_idx]) begin
          done = 1'b1;
        end else if (bus.s_ack) begin
          bus.m_ack[gnt_idx] = 1'b1;
          if (bus.m_cmd[gnt_idx]) begin
            done = 1'b1;
          end else if (bus.s_resp) begin
            bus.m_resp[gnt_idx] = 1'b1;
            done                = 1'b1;
          end else begin
            state_nxt = ARB_RESP;
          end
        end
`ifdef XBAR_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          bus.m_ack[gnt_idx] = 1'b1;
          to_fire            = 1'b1;
          done               = 1'b1;
        end
`endif
      end
      ARB_RESP: begin
        bus.grant[gnt_idx] = 1'b1;
        if (bus.s_resp) begin
          bus.m_resp[gnt_idx] = 1'b1;
          done                = 1'b1;
        end
`ifdef XBAR_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          bus.m_resp[gnt_idx] = 1'b1;
          bus.m_rdata         = TIMEOUT_RDATA;
          to_fire             = 1'b1;
          done                = 1'b1;
        end
`endif
      end
      default: state_nxt = ARB_IDLE;
    endcase

    if (done) begin
      state_nxt = ARB_IDLE;
      rr_nxt    = (gnt_idx == IW'(N_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Randomized scoreboard bench for xbar_slave_arbiter (N_MASTERS=4, SLAVE_ID=2).
`timescale 1ns/1ps
module tb_xbar_slave_arbiter;
  import xbar_pkg::*;

  localparam int N   = 4;
  localparam int SID = 2;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  xbar_slave_arbiter_if #(.N_MASTERS(N)) bus();

  xbar_slave_arbiter #(.N_MASTERS(N), .SLAVE_ID(SID), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          model_ptr = 0;
  logic [31:0] tx_addr [N];
  logic        tx_cmd  [N];
  logic [31:0] tx_wdata[N];
  logic [N-1:0] ack_seen = '0;
  bit          rd_pending = 0;
  int          rd_mst = 0;
  logic [31:0] rd_exp = '0;
  bit          manual = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] oh(input int m);
    logic [31:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  // Reference: each held eligible request is served in round-robin order from the pointer,
  // and the pointer moves past each winner.
  task automatic plan_round(input logic [N-1:0] elig);
    logic [N-1:0] left;
    txn_t t;
    left = elig;
    while (left != '0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (model_ptr + k) % N;
        if (left[c]) begin
          t.mst = c; t.addr = tx_addr[c]; t.cmd = tx_cmd[c]; t.wdata = tx_wdata[c];
          sb.push_back(t);
          left[c] = 1'b0;
          model_ptr = (c + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic drive_master(input int i, input bit req, input bit elig, input logic cmd);
    logic [31:0] a;
    a = $urandom;
    a[31:30] = elig ? 2'(SID) : 2'((SID + 1 + $urandom_range(0, 2)) % 4);
    tx_addr[i] = a; tx_cmd[i] = cmd; tx_wdata[i] = $urandom;
    bus.m_addr[i] = a; bus.m_cmd[i] = cmd; bus.m_wdata[i] = tx_wdata[i];
    bus.m_req[i] = req;
  endtask

  task automatic run_round(input logic [N-1:0] req, input logic [N-1:0] elig);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) drive_master(i, req[i], elig[i], 1'($urandom));
    plan_round(elig & req);
    for (int cyc = 0; ; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (ack_seen[i]) bus.m_req[i] = 1'b0;
      if (cyc >= 3 && sb.size() == 0 && !rd_pending) break;
      if (cyc > 300) begin
        chk("round_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        break;
      end
    end
    bus.m_req = '0;
  endtask

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    ack_seen = bus.m_ack;
    if (bus.grant == '0)
      chk("idle_quiet", {bus.s_req, 1'b0, bus.m_ack, 2'b0, bus.m_resp, 21'(bus.s_addr != 0)}, 32'd0);
    if (!reset_n) begin
      rd_pending = 0;
    end else if (bus.timeout_err) begin
      rd_pending = 0;
    end else begin
      chk("rdata_mirror", bus.m_rdata, bus.s_rdata);
      if (bus.s_req && bus.s_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_accept", bus.grant, 32'd0);
        end else begin
          txn_t t;
          t = sb.pop_front();
          chk("grant", 32'(bus.grant), oh(t.mst));
          chk("s_addr", bus.s_addr, t.addr);
          chk("s_cmd", 32'(bus.s_cmd), 32'(t.cmd));
          if (t.cmd) chk("s_wdata", bus.s_wdata, t.wdata);
          chk("m_ack", 32'(bus.m_ack), oh(t.mst));
          if (t.cmd) begin
            chk("wr_no_resp", 32'(bus.m_resp), 32'd0);
          end else if (bus.s_resp) begin
            chk("m_resp_same", 32'(bus.m_resp), oh(t.mst));
            chk("m_rdata_same", bus.m_rdata, rd_f(t.addr));
          end else begin
            rd_pending = 1; rd_mst = t.mst; rd_exp = rd_f(t.addr);
          end
        end
      end else begin
        chk("no_stray_ack", 32'(bus.m_ack), 32'd0);
        if (rd_pending) chk("sreq_low_resp", 32'(bus.s_req), 32'd0);
        if (rd_pending && bus.s_resp) begin
          chk("resp_grant", 32'(bus.grant), oh(rd_mst));
          chk("m_resp", 32'(bus.m_resp), oh(rd_mst));
          chk("m_rdata", bus.m_rdata, rd_exp);
          rd_pending = 0;
        end else begin
          chk("no_stray_resp", 32'(bus.m_resp), 32'd0);
        end
      end
    end
  end

  // Randomized slave: ack after 0..2 cycles, read response 0..2 cycles after ack,
  // plus stray ack/resp pulses in states where they must be ignored.
  initial begin
    int ack_dly, resp_dly;
    logic [31:0] pend_rd;
    bus.s_ack = 1'b0; bus.s_resp = 1'b0; bus.s_rdata = '0;
    ack_dly = 0; resp_dly = 0; pend_rd = '0;
    forever begin
      @(posedge clk); #2;
      if (manual) begin
        resp_dly = 0;
        continue;
      end
      bus.s_ack = 1'b0; bus.s_resp = 1'b0; bus.s_rdata = $urandom;
      if (resp_dly > 0) begin
        resp_dly--;
        if (resp_dly == 0) begin bus.s_resp = 1'b1; bus.s_rdata = pend_rd; end
      end else if (bus.s_req) begin
        if (ack_dly == 0) begin
          bus.s_ack = 1'b1;
          ack_dly = $urandom_range(0, 2);
          if (!bus.s_cmd) begin
            int r;
            r = $urandom_range(0, 2);
            pend_rd = rd_f(bus.s_addr);
            if (r == 0) begin bus.s_resp = 1'b1; bus.s_rdata = pend_rd; end
            else resp_dly = r;
          end
        end else begin
          ack_dly--;
        end
      end else if (bus.grant == '0) begin
        bus.s_ack = ($urandom_range(0, 3) == 0);
        bus.s_resp = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic wait_sreq(input string name);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #2;
      if (bus.s_req) return;
    end
    chk(name, 32'(bus.s_req), 32'd1);
  endtask

  task automatic reset_mid_read();
    @(posedge clk); #1;
    manual = 1; bus.s_ack = 1'b0; bus.s_resp = 1'b0;
    drive_master(1, 1'b1, 1'b1, 1'b0);
    plan_round(4'b0010);
    wait_sreq("rst_wait_sreq");
    bus.s_ack = 1'b1; bus.s_rdata = 32'h55;
    @(posedge clk); #2;
    bus.s_ack = 1'b0;
    chk("resp_sreq_low", 32'(bus.s_req), 32'd0);
    chk("resp_grant_held", 32'(bus.grant), 32'h2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_sreq_drop", 32'(bus.s_req), 32'd0);
    chk("rst_grant_drop", 32'(bus.grant), 32'd0);
    bus.m_req = '0;
    @(posedge clk); #2; bus.s_resp = 1'b1;
    @(posedge clk); #2; bus.s_resp = 1'b0; reset_n = 1'b1;
    @(posedge clk); #2; bus.s_resp = 1'b1; bus.s_ack = 1'b1;
    @(posedge clk); #2; bus.s_resp = 1'b0; bus.s_ack = 1'b0;
    model_ptr = 0;
    manual = 0;
  endtask

`ifdef XBAR_ARB_TIMEOUT_EN
  task automatic timeout_checks();
    int cnt;
    @(posedge clk); #1;
    manual = 1; bus.s_ack = 1'b0; bus.s_resp = 1'b0;
    drive_master(0, 1'b1, 1'b1, 1'b1);
    model_ptr = 1;
    cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.grant != '0) cnt++;
      if (bus.timeout_err) break;
    end
    chk("to_wr_err", 32'(bus.timeout_err), 32'd1);
    chk("to_wr_cycle", 32'(cnt), 32'(TO + 1));
    chk("to_wr_ack", 32'(bus.m_ack), 32'h1);
    @(posedge clk); #1; bus.m_req = '0;
    drive_master(1, 1'b1, 1'b1, 1'b0);
    plan_round(4'b0010);
    wait_sreq("to_rd_wait_sreq");
    bus.s_ack = 1'b1;
    @(posedge clk); #2; bus.s_ack = 1'b0; bus.m_req = '0;
    cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.grant != '0) cnt++;
      if (bus.timeout_err) break;
    end
    chk("to_rd_err", 32'(bus.timeout_err), 32'd1);
    chk("to_rd_cycle", 32'(cnt), 32'(TO + 1));
    chk("to_rd_resp", 32'(bus.m_resp), 32'h2);
    chk("to_rd_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #2;
    manual = 0;
  endtask
`endif

  initial begin
    logic [N-1:0] req, elig;
    bus.m_req = '0; bus.m_addr = '0; bus.m_cmd = '0; bus.m_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_s_req", 32'(bus.s_req), 32'd0);
    chk("rst_m_ack", 32'(bus.m_ack), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    reset_n = 1'b1;
    run_round(4'b1111, 4'b1111);
    for (int r = 0; r < 40; r++) begin
      req = N'($urandom);
      elig = '0;
      for (int i = 0; i < N; i++) elig[i] = ($urandom_range(0, 3) != 0);
      run_round(req, elig);
    end
    run_round(4'b0100, 4'b0000);
    reset_mid_read();
    run_round(4'b1111, 4'b1111);
    for (int r = 0; r < 20; r++) run_round(N'($urandom), 4'b1111);
`ifdef XBAR_ARB_TIMEOUT_EN
    timeout_checks();
    run_round(4'b1111, 4'b1111);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
